// File: rtl/alu_pkg.sv
// Shared encodings for the 4-bit ALU front end: op codes, display stages and
// the entry sequencer state machine.
package alu_pkg;

    localparam logic [1:0] OP_XOR = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    localparam logic [1:0] STAGE_A    = 2'b00;
    localparam logic [1:0] STAGE_B    = 2'b01;
    localparam logic [1:0] STAGE_OP   = 2'b10;
    localparam logic [1:0] STAGE_SHOW = 2'b11;

    typedef enum logic [3:0] {
        WAIT_A,
        SETUP_A,
        PULSE_A,
        WAIT_B,
        SETUP_B,
        PULSE_B,
        WAIT_OP,
        SETUP_RUN,
        PULSE_RUN,
        SHOW
    } seq_state_t;

    function automatic logic [1:0] stage_of(input seq_state_t s);
        case (s)
            WAIT_A, SETUP_A, PULSE_A:        stage_of = STAGE_A;
            WAIT_B, SETUP_B, PULSE_B:        stage_of = STAGE_B;
            WAIT_OP, SETUP_RUN, PULSE_RUN:   stage_of = STAGE_OP;
            default:                         stage_of = STAGE_SHOW;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counter debouncer for a raw push button; emits a
// one-cycle press pulse when the accepted level rises.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync1;
    logic        sync2;
    logic        level;
    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // sample has disagreed long enough: accept it, flag rising edges
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/alu_entry_sequencer.sv
// Sequences operand A, operand B and op entry for the 4-bit ALU from debounced
// ENTER/CLEAR presses, producing registered load/run strobes with setup time.
module alu_entry_sequencer
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_enter,
    input  logic       btn_clear,
    input  logic [3:0] sw_data,
    input  logic [1:0] sw_op,
    output logic [3:0] data_out,
    output logic [1:0] op_select,
    output logic       load1,
    output logic       load2,
    output logic       run,
    output logic [1:0] stage,
    output logic       result_valid
);

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);

    logic       enter;
    logic       clear;
    logic       enter_ok;
    logic [7:0] pcnt;
    seq_state_t state;
    seq_state_t next_state;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_enter),
        .press (enter)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_clear),
        .press (clear)
    );

    // clear beats a coincident enter
    assign enter_ok = enter && !clear;

    always_comb begin
        next_state = state;
        case (state)
            WAIT_A:    if (enter_ok) next_state = SETUP_A;
            SETUP_A:   next_state = PULSE_A;
            PULSE_A:   if (pcnt == 8'd0) next_state = WAIT_B;
            WAIT_B:    if (enter_ok) next_state = SETUP_B;
            SETUP_B:   next_state = PULSE_B;
            PULSE_B:   if (pcnt == 8'd0) next_state = WAIT_OP;
            WAIT_OP:   if (enter_ok) next_state = SETUP_RUN;
            SETUP_RUN: next_state = PULSE_RUN;
            PULSE_RUN: if (pcnt == 8'd0) next_state = SHOW;
            SHOW:      if (enter_ok) next_state = SETUP_RUN;
            default:   next_state = WAIT_A;
        endcase
        if (clear) next_state = WAIT_A;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_A;
            pcnt  <= '0;
        end else begin
            state <= next_state;
            if (state == SETUP_A || state == SETUP_B || state == SETUP_RUN)
                pcnt <= PULSE_LOAD;
            else if ((state == PULSE_A || state == PULSE_B || state == PULSE_RUN) && pcnt != 8'd0)
                pcnt <= pcnt - 8'd1;
        end
    end

    // Outputs are decoded from next_state so they register alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out     <= '0;
            op_select    <= OP_XOR;
            load1        <= 1'b0;
            load2        <= 1'b0;
            run          <= 1'b0;
            stage        <= STAGE_A;
            result_valid <= 1'b0;
        end else begin
            if (enter_ok && (state == WAIT_A || state == WAIT_B))
                data_out <= sw_data;
            if (enter_ok && (state == WAIT_OP || state == SHOW))
                op_select <= sw_op;
            load1        <= (next_state == PULSE_A);
            load2        <= (next_state == PULSE_B);
            run          <= (next_state == PULSE_RUN);
            stage        <= stage_of(next_state);
            result_valid <= (next_state == SHOW);
        end
    end

endmodule

// File: tb/tb_alu_entry_sequencer.sv
// Scoreboard bench: stimulus queues the expected strobe events, a negedge
// monitor pops and checks each strobe, its data/op, width and the ALU result.
module tb_alu_entry_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_enter = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_enter_l = 1'b0;
    logic       btn_clear_l = 1'b0;
    logic [3:0] sw_data = 4'd0;
    logic [1:0] sw_op = 2'd0;
    logic [3:0] data_out, data_out_l;
    logic [1:0] op_select, op_select_l;
    logic       load1, load2, run, result_valid;
    logic       load1_l, load2_l, run_l, result_valid_l;
    logic [1:0] stage, stage_l;

    alu_entry_sequencer #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .btn_enter(btn_enter), .btn_clear(btn_clear),
        .sw_data(sw_data), .sw_op(sw_op), .data_out(data_out), .op_select(op_select),
        .load1(load1), .load2(load2), .run(run), .stage(stage), .result_valid(result_valid)
    );

    // long-pulse instance so a second press can land inside PULSE_A
    alu_entry_sequencer #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(16)) dut_l (
        .clk(clk), .rst_n(rst_n), .btn_enter(btn_enter_l), .btn_clear(btn_clear_l),
        .sw_data(sw_data), .sw_op(sw_op), .data_out(data_out_l), .op_select(op_select_l),
        .load1(load1_l), .load2(load2_l), .run(run_l), .stage(stage_l), .result_valid(result_valid_l)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 1 load1, 2 load2, 3 run
        int data;
        int op;
        int width;
        int stage;
        int result;
        bit trunc;
    } exp_t;

    exp_t q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic void push(input int k, input int d, input int o, input int w,
                                 input int st, input int r, input bit t);
        exp_t e;
        e.kind = k; e.data = d; e.op = o; e.width = w; e.stage = st; e.result = r; e.trunc = t;
        q.push_back(e);
    endfunction

    // attached ALU model
    logic [3:0] a_reg = 4'd0, b_reg = 4'd0, acc = 4'd0;
    always @(posedge clk) begin
        if (load1) a_reg <= data_out;
        if (load2) b_reg <= data_out;
        if (run) begin
            case (op_select)
                2'b00: acc <= a_reg ^ b_reg;
                2'b01: acc <= a_reg + b_reg;
                2'b10: acc <= a_reg - b_reg;
                default: acc <= 4'(a_reg * b_reg);
            endcase
        end
    end

    logic [2:0] prev_s = 3'b000;
    int         width = 0;
    bit         have = 1'b0;
    exp_t       cur;

    always @(negedge clk) begin
        logic [2:0] s;
        s = {run, load2, load1};
        if (s != 3'b000 && prev_s == 3'b000) begin
            if (q.size() == 0) begin
                chk("spurious_strobe", int'(s), 0);
                have = 1'b0;
            end else begin
                cur = q.pop_front();
                have = 1'b1;
                width = 0;
                chk("strobe_kind", int'(s), 1 << (cur.kind - 1));
            end
        end
        if (s != 3'b000) begin
            width++;
            chk("strobe_onehot", $countones(s), 1);
            if (have) begin
                chk("data_hold", int'(data_out), cur.data);
                chk("op_hold", int'(op_select), cur.op);
            end
        end
        if (s == 3'b000 && prev_s != 3'b000 && have) begin
            chk("pulse_width", width, cur.width);
            chk("stage_after", int'(stage), cur.stage);
            if (cur.kind == 3 && !cur.trunc) begin
                chk("result_valid", int'(result_valid), 1);
                chk("alu_acc", int'(acc), cur.result);
            end
            have = 1'b0;
        end
        prev_s = s;
    end

    int l1_cnt = 0, l2_cnt = 0;
    logic l1_prev = 1'b0, l2_prev = 1'b0;
    always @(negedge clk) begin
        if (load1_l && !l1_prev) l1_cnt++;
        if (load2_l && !l2_prev) l2_cnt++;
        l1_prev = load1_l;
        l2_prev = load2_l;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // which: 0 enter, 1 clear, 2 enter+clear, 3 enter on long instance
    task automatic pulse_btn(input int which, input int hold, input int gap);
        if (which == 0 || which == 2) btn_enter = 1'b1;
        if (which == 1 || which == 2) btn_clear = 1'b1;
        if (which == 3) btn_enter_l = 1'b1;
        step(hold);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        btn_enter_l = 1'b0;
        step(gap);
    endtask

    initial begin
        #2;
        chk("rst_data", int'(data_out), 0);
        chk("rst_op", int'(op_select), 0);
        chk("rst_strobes", int'({load1, load2, run}), 0);
        chk("rst_stage", int'(stage), 0);
        chk("rst_valid", int'(result_valid), 0);
        step(2);
        rst_n = 1'b1;
        step(3);

        // clean A, B, op entry then two re-runs
        sw_data = 4'd5; push(1, 5, 0, 4, 1, 0, 0); pulse_btn(0, 12, 10);
        sw_data = 4'd2; push(2, 2, 0, 4, 2, 0, 0); pulse_btn(0, 12, 10);
        sw_op = 2'b01;  push(3, 2, 1, 4, 3, 7, 0); pulse_btn(0, 12, 10);
        sw_op = 2'b10;  push(3, 2, 2, 4, 3, 3, 0); pulse_btn(0, 12, 10);
        sw_op = 2'b11;  push(3, 2, 3, 4, 3, 10, 0); pulse_btn(0, 12, 10);

        // clear from SHOW holds snapshots
        pulse_btn(1, 12, 10);
        chk("clr_stage", int'(stage), 0);
        chk("clr_valid", int'(result_valid), 0);
        chk("clr_data_hold", int'(data_out), 2);
        chk("clr_op_hold", int'(op_select), 3);

        // bouncing enter yields a single load1
        sw_data = 4'd9;
        push(1, 9, 3, 4, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            btn_enter = 1'b1; step(2);
            btn_enter = 1'b0; step(2);
        end
        pulse_btn(0, 12, 10);

        // clear lands in the second PULSE_B cycle: load2 truncated to 2
        sw_data = 4'd6;
        push(2, 6, 3, 2, 0, 0, 1);
        btn_enter = 1'b1;
        step(3);
        btn_clear = 1'b1;
        step(10);
        btn_enter = 1'b0; btn_clear = 1'b0;
        step(10);
        chk("trunc_stage", int'(stage), 0);

        // coincident enter and clear: enter discarded
        sw_data = 4'd11;
        pulse_btn(2, 12, 10);
        chk("both_stage", int'(stage), 0);
        chk("both_data", int'(data_out), 6);

        // enter during PULSE_A of the long instance is ignored
        sw_data = 4'd3;
        pulse_btn(3, 6, 7);
        pulse_btn(3, 6, 20);
        chk("ign_l1", l1_cnt, 1);
        chk("ign_l2", l2_cnt, 0);
        chk("ign_stage", int'(stage_l), 1);
        chk("ign_data", int'(data_out_l), 3);
        sw_data = 4'd8;
        pulse_btn(3, 12, 26);
        chk("fresh_l2", l2_cnt, 1);
        chk("fresh_data", int'(data_out_l), 8);
        chk("fresh_stage", int'(stage_l), 2);

        // async reset in the middle of PULSE_RUN
        sw_data = 4'd1; push(1, 1, 3, 4, 1, 0, 0); pulse_btn(0, 12, 10);
        sw_data = 4'd4; push(2, 4, 3, 4, 2, 0, 0); pulse_btn(0, 12, 10);
        sw_op = 2'b01;  push(3, 4, 1, 2, 0, 0, 1);
        btn_enter = 1'b1;
        step(10);
        rst_n = 1'b0;
        #1;
        chk("arst_run", int'(run), 0);
        chk("arst_data", int'(data_out), 0);
        chk("arst_op", int'(op_select), 0);
        chk("arst_stage", int'(stage), 0);
        btn_enter = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(5);
        sw_data = 4'd7; push(1, 7, 0, 4, 1, 0, 0); pulse_btn(0, 12, 10);
        chk("post_rst_stage", int'(stage), 1);
        chk("post_rst_data", int'(data_out), 7);

        step(5);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
